mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single physical-memory port between instruction fetch (IFU, req 0) and
//  load/store (LSU, req 1). Arbitrates round-robin and latches the winning request.
//  Sequences the memory valid/ready request and response handshake, then routes the
//  response back to the owner. Sits between pc/ifu/exu and the pmem DPI wrapper, so
//  the core's two combinational pmem accesses become one serialised port.
// PARAMETERS
//  ISA_WIDTH   32   address/data width
//  MASK_WIDTH  8    write byte-mask width
//  TIMEOUT     255  max cycles in RSP before abort; 8-bit counter, 1..255
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous active-high reset
//  ifu_req_valid  in   1           fetch request
//  ifu_req_ready  out  1           fetch request accepted this cycle
//  ifu_addr       in   ISA_WIDTH   fetch address
//  ifu_rsp_valid  out  1           1-cycle pulse: fetch data valid
//  ifu_rdata      out  ISA_WIDTH   fetch data, held until next ifu response
//  lsu_req_valid  in   1           load/store request
//  lsu_req_ready  out  1           load/store request accepted
//  lsu_addr       in   ISA_WIDTH   load/store address
//  lsu_wen        in   1           1=store, 0=load
//  lsu_wdata      in   ISA_WIDTH   store data
//  lsu_wmask      in   MASK_WIDTH  store byte mask
//  lsu_rsp_valid  out  1           1-cycle pulse: load data / store ack
//  lsu_rdata      out  ISA_WIDTH   load data, held until next lsu response
//  mem_req_valid  out  1           request to memory
//  mem_req_ready  in   1           memory accepts request
//  mem_addr/mem_wdata out ISA_WIDTH, mem_wmask out MASK_WIDTH, mem_wen out 1: latched request
//  mem_rsp_valid  in   1           memory response strobe
//  mem_rdata      in   ISA_WIDTH   memory response data
//  timeout_err    out  1           sticky: a response timed out
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=LSU (IFU wins first tie), all outputs, latches and counter 0.
//  States are IDLE, REQ and RSP. Only IDLE accepts requests, so at most one transaction
//   is outstanding.
//  IDLE: the winner is the single valid requester. If both are valid, the winner is the
//   one not equal to last_grant. winner_req_ready=1 combinationally; the other ready=0.
//   On handshake: latch addr/wdata/wmask/wen (IFU: wen=0, wmask=0), owner<=winner,
//   last_grant<=winner, go to REQ.
//  REQ: mem_req_valid=1 with latched fields, stable until mem_req_ready. On ready go to RSP
//   and clear the counter. mem_rsp_valid is ignored in REQ.
//  RSP: mem_req_valid=0; counter increments each cycle. On mem_rsp_valid: owner
//   rsp_valid=1 for exactly the next cycle (registered). Owner rdata<=mem_rdata (stores:
//   rdata unchanged). Go to IDLE.
//  Timeout: if counter reaches TIMEOUT with no rsp, set timeout_err=1 (held until rst).
//   Pulse owner rsp_valid with rdata<=0 and go to IDLE.
//  Latency: accept (cycle 0) -> mem_req_valid at cycle 1. Rsp seen in cycle N ->
//   owner rsp_valid at N+1. Minimum is 3 cycles per transaction; back-to-back grants
//   alternate when both requesters stay valid.
//  Stray mem_rsp_valid in IDLE/REQ: dropped, no state change.
//  Reset mid-transaction: the transaction is abandoned with no response pulse. Any later
//   memory response is dropped as stray.
//  A requester's valid may drop before acceptance with no effect.
// TESTING
//  Single IFU read of addr 0x80000000, mem replies 0x00100073 after 2 cycles ->
//   ifu_rsp_valid 1 cycle, ifu_rdata=0x00100073, lsu_rsp_valid stays 0.
//  Both valid from reset, held for 4 transactions -> grant order IFU,LSU,IFU,LSU and
//   the mem_addr sequence matches.
//  LSU store addr 0x80000100, wdata 0xdeadbeef, wmask 0x0f, mem_req_ready low 3 cycles ->
//   mem_* fields stable while valid, one lsu_rsp_valid, lsu_rdata unchanged.
//  TIMEOUT=4, memory never responds -> timeout_err=1 after 4 RSP cycles, lsu_rdata=0,
//   next request still served, timeout_err stays 1.
//  rst in RSP followed by a late mem_rsp_valid -> no rsp_valid pulse on either side,
//   state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Serialises instruction-fetch (IFU) and load/store (LSU) accesses
//            onto one physical-memory port. Round-robin grant, one outstanding
//            transaction, valid/ready request and response handshakes, with a
//            response timeout that flags a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ISA_WIDTH  = 32,
   parameter int MASK_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction fetch requester
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ISA_WIDTH-1:0]  ifu_addr,
   output logic                  ifu_rsp_valid,
   output logic [ISA_WIDTH-1:0]  ifu_rdata,
   // load/store requester
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ISA_WIDTH-1:0]  lsu_addr,
   input  logic                  lsu_wen,
   input  logic [ISA_WIDTH-1:0]  lsu_wdata,
   input  logic [MASK_WIDTH-1:0] lsu_wmask,
   output logic                  lsu_rsp_valid,
   output logic [ISA_WIDTH-1:0]  lsu_rdata,
   // physical memory port
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ISA_WIDTH-1:0]  mem_addr,
   output logic [ISA_WIDTH-1:0]  mem_wdata,
   output logic [MASK_WIDTH-1:0] mem_wmask,
   output logic                  mem_wen,
   input  logic                  mem_rsp_valid,
   input  logic [ISA_WIDTH-1:0]  mem_rdata,
   // status
   output logic                  timeout_err
);

   // Requester identifiers used for grant history and transaction ownership
   localparam logic c_sel_ifu = 1'b0;
   localparam logic c_sel_lsu = 1'b1;

   // Last counter value before the timeout fires: the RSP cycle in which the
   // counter would reach TIMEOUT is the one that aborts.
   localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_last_grant;
   logic                  r_owner;
   logic [7:0]            r_cnt;
   logic [ISA_WIDTH-1:0]  r_addr;
   logic [ISA_WIDTH-1:0]  r_wdata;
   logic [MASK_WIDTH-1:0] r_wmask;
   logic                  r_wen;
   logic                  r_ifu_rsp_valid;
   logic                  r_lsu_rsp_valid;
   logic [ISA_WIDTH-1:0]  r_ifu_rdata;
   logic [ISA_WIDTH-1:0]  r_lsu_rdata;
   logic                  r_timeout_err;

   logic                  w_idle;
   logic                  w_pick_ifu;
   logic                  w_pick_lsu;

   assign w_idle = (r_state == ST_IDLE);

   // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
   always_comb begin
      w_pick_ifu = 1'b0;
      w_pick_lsu = 1'b0;
      if (ifu_req_valid && lsu_req_valid) begin
         w_pick_ifu = (r_last_grant == c_sel_lsu);
         w_pick_lsu = (r_last_grant == c_sel_ifu);
      end else begin
         w_pick_ifu = ifu_req_valid;
         w_pick_lsu = lsu_req_valid;
      end
   end

   assign ifu_req_ready = w_idle && w_pick_ifu;
   assign lsu_req_ready = w_idle && w_pick_lsu;

   assign mem_req_valid = (r_state == ST_REQ);
   assign mem_addr      = r_addr;
   assign mem_wdata     = r_wdata;
   assign mem_wmask     = r_wmask;
   assign mem_wen       = r_wen;

   assign ifu_rsp_valid = r_ifu_rsp_valid;
   assign lsu_rsp_valid = r_lsu_rsp_valid;
   assign ifu_rdata     = r_ifu_rdata;
   assign lsu_rdata     = r_lsu_rdata;
   assign timeout_err   = r_timeout_err;

   // Transaction sequencer: grant/latch in IDLE, hold request in REQ, wait for data in RSP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_last_grant    <= c_sel_lsu;
         r_owner         <= c_sel_ifu;
         r_cnt           <= 8'd0;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_wmask         <= '0;
         r_wen           <= 1'b0;
         r_ifu_rsp_valid <= 1'b0;
         r_lsu_rsp_valid <= 1'b0;
         r_ifu_rdata     <= '0;
         r_lsu_rdata     <= '0;
         r_timeout_err   <= 1'b0;
      end else begin
         // response strobes are single-cycle pulses by default
         r_ifu_rsp_valid <= 1'b0;
         r_lsu_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_ifu) begin
                  r_addr       <= ifu_addr;
                  r_wdata      <= '0;
                  r_wmask      <= '0;
                  r_wen        <= 1'b0;
                  r_owner      <= c_sel_ifu;
                  r_last_grant <= c_sel_ifu;
                  r_state      <= ST_REQ;
               end else if (w_pick_lsu) begin
                  r_addr       <= lsu_addr;
                  r_wdata      <= lsu_wdata;
                  r_wmask      <= lsu_wmask;
                  r_wen        <= lsu_wen;
                  r_owner      <= c_sel_lsu;
                  r_last_grant <= c_sel_lsu;
                  r_state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // memory responses arriving before the request is taken are stray
               if (mem_req_ready) begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (mem_rsp_valid) begin
                  if (r_owner == c_sel_ifu) begin
                     r_ifu_rsp_valid <= 1'b1;
                     r_ifu_rdata     <= mem_rdata;
                  end else begin
                     r_lsu_rsp_valid <= 1'b1;
                     // a store acknowledge carries no data
                     if (!r_wen) begin
                        r_lsu_rdata <= mem_rdata;
                     end
                  end
                  r_state <= ST_IDLE;
               end else if (r_cnt == c_cnt_last) begin
                  // abort: release the owner with zero data and flag the error
                  r_timeout_err <= 1'b1;
                  if (r_owner == c_sel_ifu) begin
                     r_ifu_rsp_valid <= 1'b1;
                     r_ifu_rdata     <= '0;
                  end else begin
                     r_lsu_rsp_valid <= 1'b1;
                     r_lsu_rdata     <= '0;
                  end
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter. Directed scenarios plus
//            randomized transactions compared against a transaction-level
//            reference (round-robin rule, expected latched fields, held data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int   W   = 32;
   localparam int   M   = 8;
   localparam logic IFU = 1'b0;
   localparam logic LSU = 1'b1;

   logic         clk;
   logic         rst;
   logic         ifu_req_valid;
   logic         ifu_req_ready;
   logic [W-1:0] ifu_addr;
   logic         ifu_rsp_valid;
   logic [W-1:0] ifu_rdata;
   logic         lsu_req_valid;
   logic         lsu_req_ready;
   logic [W-1:0] lsu_addr;
   logic         lsu_wen;
   logic [W-1:0] lsu_wdata;
   logic [M-1:0] lsu_wmask;
   logic         lsu_rsp_valid;
   logic [W-1:0] lsu_rdata;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_wdata;
   logic [M-1:0] mem_wmask;
   logic         mem_wen;
   logic         mem_rsp_valid;
   logic [W-1:0] mem_rdata;
   logic         timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   // reference state: who was granted last, and the data each side should hold
   logic         last_win;
   logic [W-1:0] exp_ifu_rd;
   logic [W-1:0] exp_lsu_rd;

   mem_port_arbiter #(.ISA_WIDTH(W), .MASK_WIDTH(M), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_wen(mem_wen), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Round-robin rule: lone requester wins, a tie goes to the side not granted last
   function automatic logic pick(input logic iv, input logic lv, input logic last);
      if (iv && lv) return ~last;
      return lv;
   endfunction

   // Inputs are driven just after the falling edge and outputs sampled 1ns later
   task automatic next_cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      next_cyc();
      next_cyc();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen, timeout_err} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen, timeout_err});
      end
      n_cmp++;
      if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h want all zero", {ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask});
      end
      last_win   = LSU;
      exp_ifu_rd = '0;
      exp_lsu_rd = '0;
   endtask

   task automatic test_alternate();
      logic         exp_w;
      logic [W-1:0] rd;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0400; lsu_wen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp_w = pick(1'b1, 1'b1, last_win);
         n_cmp++;
         if ({ifu_req_ready, lsu_req_ready} !== {exp_w == IFU, exp_w == LSU}) begin
            n_err++;
            $display("FAIL alt_grant[%0d]: got ready %b want %b", k,
                     {ifu_req_ready, lsu_req_ready}, {exp_w == IFU, exp_w == LSU});
         end
         next_cyc();
         #1;
         n_cmp++;
         if ({mem_req_valid, mem_addr} !== {1'b1, ((exp_w == IFU) ? ifu_addr : lsu_addr)}) begin
            n_err++;
            $display("FAIL alt_mem_addr[%0d]: got %b/%h want 1/%h", k, mem_req_valid, mem_addr,
                     (exp_w == IFU) ? ifu_addr : lsu_addr);
         end
         mem_req_ready = 1'b1;
         next_cyc();
         mem_req_ready = 1'b0;
         rd = ((exp_w == IFU) ? 32'h1111_0000 : 32'h2222_0000) + 32'(k);
         mem_rsp_valid = 1'b1; mem_rdata = rd;
         next_cyc();
         mem_rsp_valid = 1'b0;
         if (k == 3) begin
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
         end
         #1;
         if (exp_w == IFU) exp_ifu_rd = rd;
         else              exp_lsu_rd = rd;
         n_cmp++;
         if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, lsu_rdata} !== {exp_w == IFU, exp_w == LSU, exp_ifu_rd, exp_lsu_rd}) begin
            n_err++;
            $display("FAIL alt_rsp[%0d]: got %b%b %h %h want %b%b %h %h", k, ifu_rsp_valid, lsu_rsp_valid,
                     ifu_rdata, lsu_rdata, exp_w == IFU, exp_w == LSU, exp_ifu_rd, exp_lsu_rd);
         end
         last_win = exp_w;
      end
   endtask

   task automatic test_single_ifu();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL ifu_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
      end
      next_cyc();
      ifu_req_valid = 1'b0;
      #1;
      n_cmp++;
      if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL ifu_mem_req: got %b %h %b %h want 1 80000000 0 00", mem_req_valid, mem_addr, mem_wen, mem_wmask);
      end
      mem_req_ready = 1'b1;
      next_cyc();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL ifu_wait[%0d]: got %b want 000", i, {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid});
         end
         next_cyc();
      end
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
      next_cyc();
      mem_rsp_valid = 1'b0;
      #1;
      exp_ifu_rd = 32'h0010_0073;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata} !== {2'b10, 32'h0010_0073}) begin
         n_err++;
         $display("FAIL ifu_rsp: got %b%b %h want 10 00100073", ifu_rsp_valid, lsu_rsp_valid, ifu_rdata);
      end
      next_cyc();
      #1;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL ifu_pulse_len: got %b want 00", {ifu_rsp_valid, lsu_rsp_valid});
      end
      last_win = IFU;
   endtask

   task automatic test_store_stall();
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
      lsu_wdata = 32'hdead_beef; lsu_wmask = 8'h0f;
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL st_ready: got %b want 01", {ifu_req_ready, lsu_req_ready});
      end
      next_cyc();
      // scrub the inputs: the port must present the latched copy
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_wen} !== {1'b1, 32'h8000_0100, 32'hdead_beef, 8'h0f, 1'b1}) begin
            n_err++;
            $display("FAIL st_hold[%0d]: got %b %h %h %h %b want 1 80000100 deadbeef 0f 1", i,
                     mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_wen);
         end
         mem_rsp_valid = (i == 1);   // stray strobe while the request is pending
         mem_req_ready = (i == 3);
         next_cyc();
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
      next_cyc();
      mem_rsp_valid = 1'b0;
      #1;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid, lsu_rdata} !== {2'b01, exp_lsu_rd}) begin
         n_err++;
         $display("FAIL st_ack: got %b%b %h want 01 %h", ifu_rsp_valid, lsu_rsp_valid, lsu_rdata, exp_lsu_rd);
      end
      next_cyc();
      #1;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL st_pulse_len: got %b want 00", {ifu_rsp_valid, lsu_rsp_valid});
      end
      last_win = LSU;
   endtask

   task automatic test_timeout();
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL to_ready: got %b want 01", {ifu_req_ready, lsu_req_ready});
      end
      next_cyc();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      next_cyc();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if ({timeout_err, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL to_wait[%0d]: got %b want 0000", i, {timeout_err, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid});
         end
         next_cyc();
      end
      #1;
      exp_lsu_rd = '0;
      n_cmp++;
      if ({timeout_err, ifu_rsp_valid, lsu_rsp_valid, lsu_rdata} !== {3'b101, 32'h0}) begin
         n_err++;
         $display("FAIL to_abort: got %b%b%b %h want 101 00000000", timeout_err, ifu_rsp_valid, lsu_rsp_valid, lsu_rdata);
      end
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL to_next_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
      end
      next_cyc();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      next_cyc();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0013;
      next_cyc();
      mem_rsp_valid = 1'b0;
      #1;
      exp_ifu_rd = 32'h0000_0013;
      n_cmp++;
      if ({timeout_err, ifu_rsp_valid, lsu_rsp_valid, ifu_rdata} !== {3'b110, 32'h0000_0013}) begin
         n_err++;
         $display("FAIL to_next_rsp: got %b%b%b %h want 110 00000013", timeout_err, ifu_rsp_valid, lsu_rsp_valid, ifu_rdata);
      end
      last_win = IFU;
   endtask

   task automatic test_reset_mid();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL rm_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
      end
      next_cyc();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      next_cyc();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      mem_rsp_valid = 1'b1; mem_rdata = 32'hcafe_f00d;
      #1;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, timeout_err, ifu_rdata, lsu_rdata, mem_addr} !== '0) begin
         n_err++;
         $display("FAIL rm_after_rst: got %b%b%b%b %h %h %h want all zero", ifu_rsp_valid, lsu_rsp_valid,
                  mem_req_valid, timeout_err, ifu_rdata, lsu_rdata, mem_addr);
      end
      next_cyc();
      mem_rsp_valid = 1'b0;
      #1;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, timeout_err, ifu_req_ready, lsu_req_ready, ifu_rdata, lsu_rdata} !== '0) begin
         n_err++;
         $display("FAIL rm_stray: got %b%b%b%b%b%b %h %h want all zero", ifu_rsp_valid, lsu_rsp_valid, mem_req_valid,
                  timeout_err, ifu_req_ready, lsu_req_ready, ifu_rdata, lsu_rdata);
      end
      last_win   = LSU;
      exp_ifu_rd = '0;
      exp_lsu_rd = '0;
   endtask

   task automatic test_random();
      logic         iv, lv, win, wen;
      logic [W-1:0] a_i, a_l, wd, rd;
      logic [M-1:0] wm;
      int           stall, dly;
      for (int t = 0; t < 40; t++) begin
         iv = 1'($urandom_range(0, 1));
         lv = 1'($urandom_range(0, 1));
         if (!iv && !lv) begin
            if ($urandom_range(0, 1) == 0) iv = 1'b1;
            else                           lv = 1'b1;
         end
         a_i = $urandom; a_l = $urandom; wd = $urandom;
         wen = 1'($urandom_range(0, 1));
         wm  = 8'($urandom);
         ifu_req_valid = iv; ifu_addr = a_i;
         lsu_req_valid = lv; lsu_addr = a_l; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
         #1;
         win = pick(iv, lv, last_win);
         n_cmp++;
         if ({ifu_req_ready, lsu_req_ready} !== {win == IFU, win == LSU}) begin
            n_err++;
            $display("FAIL rnd_grant[%0d]: got %b want %b (valid %b%b)", t,
                     {ifu_req_ready, lsu_req_ready}, {win == IFU, win == LSU}, iv, lv);
         end
         next_cyc();
         // requesters keep changing while busy; none of it may be accepted
         ifu_req_valid = 1'($urandom); ifu_addr = $urandom;
         lsu_req_valid = 1'($urandom); lsu_addr = $urandom; lsu_wen = 1'($urandom);
         lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
         stall = $urandom_range(0, 2);
         for (int s = 0; s <= stall; s++) begin
            #1;
            n_cmp++;
            if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_addr, mem_wen, mem_wmask}
                !== {5'b10000, ((win == IFU) ? a_i : a_l), ((win == IFU) ? 1'b0 : wen), ((win == IFU) ? 8'h00 : wm)}) begin
               n_err++;
               $display("FAIL rnd_req[%0d]: got %b%b%b%b%b %h %b %h want 10000 %h %b %h", t, mem_req_valid,
                        ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_addr, mem_wen, mem_wmask,
                        (win == IFU) ? a_i : a_l, (win == IFU) ? 1'b0 : wen, (win == IFU) ? 8'h00 : wm);
            end
            if (win == LSU) begin
               n_cmp++;
               if (mem_wdata !== wd) begin
                  n_err++;
                  $display("FAIL rnd_wdata[%0d]: got %h want %h", t, mem_wdata, wd);
               end
            end
            mem_rsp_valid = 1'($urandom);
            mem_req_ready = (s == stall);
            next_cyc();
         end
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         dly = $urandom_range(0, 2);
         for (int s = 0; s < dly; s++) begin
            #1;
            n_cmp++;
            if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid} !== 5'b00000) begin
               n_err++;
               $display("FAIL rnd_wait[%0d]: got %b want 00000", t,
                        {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid});
            end
            next_cyc();
         end
         rd = $urandom;
         mem_rsp_valid = 1'b1; mem_rdata = rd;
         next_cyc();
         mem_rsp_valid = 1'b0;
         ifu_req_valid = 1'b0;
         lsu_req_valid = 1'b0;
         #1;
         if (win == IFU)  exp_ifu_rd = rd;
         else if (!wen)   exp_lsu_rd = rd;
         n_cmp++;
         if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, lsu_rdata, timeout_err}
             !== {win == IFU, win == LSU, exp_ifu_rd, exp_lsu_rd, 1'b0}) begin
            n_err++;
            $display("FAIL rnd_rsp[%0d]: got %b%b %h %h %b want %b%b %h %h 0", t, ifu_rsp_valid, lsu_rsp_valid,
                     ifu_rdata, lsu_rdata, timeout_err, win == IFU, win == LSU, exp_ifu_rd, exp_lsu_rd);
         end
         last_win = win;
      end
      next_cyc();
      #1;
      n_cmp++;
      if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL rnd_final: got %b want 000", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid});
      end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_single_ifu();
      test_store_stall();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
